// File: rtl/sync_ram_ctrl.sv
// Single-port synchronous RAM controller: byte-enabled writes, fixed-latency
// pipelined responses, range checking and an optional zero-fill after reset.
module sync_ram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int RAM_DEPTH      = 50000,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                 state_r;
  logic [IDX_W-1:0]       clr_cnt_r;
  logic [DATA_WIDTH-1:0]  mem_r [RAM_DEPTH];
  logic [RD_LATENCY-1:0]  vld_pipe_r;
  logic [RD_LATENCY-1:0]  err_pipe_r;
  logic [DATA_WIDTH-1:0]  data_pipe_r [RD_LATENCY];

  logic                   accept_s;
  logic                   in_range_s;
  logic                   wr_en_s;
  logic                   clr_en_s;
  logic [IDX_W-1:0]       idx_s;
  logic [DATA_WIDTH-1:0]  rd_word_s;

  // Request decode; a request coinciding with a reset edge is never taken.
  always_comb begin
    accept_s   = req_valid && req_ready && !rst;
    in_range_s = ({1'b0, req_addr} < DEPTH_L);
    idx_s      = req_addr[IDX_W-1:0];
    wr_en_s    = accept_s && req_we && in_range_s;
    clr_en_s   = (state_r == ST_CLEAR) && !rst;
    if (in_range_s) begin
      rd_word_s = mem_r[idx_s];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Control FSM: zero-fill sweep after reset, then steady-state request service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_r <= {IDX_W{1'b0}};
      req_ready <= 1'b0;
      busy      <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == LAST_IDX) begin
            state_r   <= ST_RUN;
            clr_cnt_r <= {IDX_W{1'b0}};
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= {IDX_W{1'b0}};
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; deliberately untouched by rst so only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clr_en_s) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem_r[idx_s][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline; stage 0 captures the word as of the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_r <= {RD_LATENCY{1'b0}};
      err_pipe_r <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_pipe_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld_pipe_r[0]  <= accept_s;
      err_pipe_r[0]  <= accept_s && !in_range_s;
      data_pipe_r[0] <= (accept_s && !req_we) ? rd_word_s : {DATA_WIDTH{1'b0}};
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        err_pipe_r[i]  <= err_pipe_r[i-1];
        data_pipe_r[i] <= data_pipe_r[i-1];
      end
    end
  end

  assign rsp_valid = vld_pipe_r[RD_LATENCY-1];
  assign rsp_err   = err_pipe_r[RD_LATENCY-1];
  assign rsp_rdata = data_pipe_r[RD_LATENCY-1];

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed bench for sync_ram_ctrl: three instances (latency 3, latency 4,
// no-clear latency 1) share one request stream; each test checks one of them.
module tb_sync_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy3, rv3, er3, bz3;
  logic [31:0] rd3;
  logic        rdy4, rv4, er4, bz4;
  logic [31:0] rd4;
  logic        rdyn, rvn, ern, bzn;
  logic [31:0] rdn;

  int checks   = 0;
  int failures = 0;

  logic        got;
  int          lat;
  logic [31:0] dat;
  logic        err;

  always #5 clk = ~clk;

  sync_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RAM_DEPTH(16), .RD_LATENCY(3), .CLEAR_ON_RESET(1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3), .busy(bz3));

  sync_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RAM_DEPTH(16), .RD_LATENCY(4), .CLEAR_ON_RESET(1)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy4), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(er4), .busy(bz4));

  sync_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RAM_DEPTH(16), .RD_LATENCY(1), .CLEAR_ON_RESET(0)) dutn (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdyn), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rvn), .rsp_rdata(rdn), .rsp_err(ern), .busy(bzn));

  // Issue one request at the current negedge and watch the selected instance
  // for its first response over a fixed 8-cycle window (also drains the others).
  task automatic req_and_wait(input int sel, input logic we, input logic [3:0] be, input logic [4:0] addr,
                              input logic [31:0] wdata, output logic o_got, output int o_lat,
                              output logic [31:0] o_dat, output logic o_err);
    logic v, e;
    logic [31:0] d;
    o_got = 1'b0; o_lat = 0; o_dat = 32'h0; o_err = 1'b0;
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      case (sel)
        3:       begin v = rv3; d = rd3; e = er3; end
        4:       begin v = rv4; d = rd4; e = er4; end
        default: begin v = rvn; d = rdn; e = ern; end
      endcase
      if (!o_got && v) begin
        o_got = 1'b1; o_lat = n; o_dat = d; o_err = e;
      end
      if (n == 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 5'd0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (rdy3 !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", rdy3); end
    checks++; if (rv3 !== 1'b0 || er3 !== 1'b0) begin failures++; $display("FAIL reset_rsp: got v=%b e=%b expected 0 0", rv3, er3); end
    checks++; if (rd3 !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rd3); end
    checks++; if (bz3 !== 1'b1 || bz4 !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b %b expected 1 1", bz3, bz4); end
    checks++; if (bzn !== 1'b0 || rdyn !== 1'b0) begin failures++; $display("FAIL reset_noclear: got busy=%b ready=%b expected 0 0", bzn, rdyn); end
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++; if (bz3 !== 1'b1 || rdy3 !== 1'b0) begin failures++; $display("FAIL clear_busy[%0d]: got busy=%b ready=%b expected 1 0", i, bz3, rdy3); end
      checks++; if (rv3 !== 1'b0) begin failures++; $display("FAIL clear_no_rsp[%0d]: got %b expected 0", i, rv3); end
      if (i == 1) begin
        checks++; if (rdyn !== 1'b1) begin failures++; $display("FAIL noclear_ready_first: got %b expected 1", rdyn); end
      end
      // requests during the sweep must be ignored (addr 2 already zeroed)
      if (i >= 10 && i <= 14) begin
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 5'd2; req_wdata = 32'h5555AAAA;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (bz3 !== 1'b0 || rdy3 !== 1'b1) begin failures++; $display("FAIL clear_done3: got busy=%b ready=%b expected 0 1", bz3, rdy3); end
    checks++; if (bz4 !== 1'b0 || rdy4 !== 1'b1) begin failures++; $display("FAIL clear_done4: got busy=%b ready=%b expected 0 1", bz4, rdy4); end
  endtask

  task automatic test_clear_read();
    req_and_wait(3, 1'b0, 4'hF, 5'd7, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || lat != 3) begin failures++; $display("FAIL clear_read7_lat: got valid=%b lat=%0d expected 1 3", got, lat); end
    checks++; if (dat !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL clear_read7: got %h err=%b expected 00000000 0", dat, err); end
    req_and_wait(3, 1'b0, 4'hF, 5'd2, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || lat != 3 || dat !== 32'h0) begin failures++; $display("FAIL clear_ignores_req: got valid=%b lat=%0d data=%h expected 1 3 00000000", got, lat, dat); end
  endtask

  task automatic test_write_then_read();
    logic exp_v;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 5'd3; req_wdata = 32'hDEADBEEF;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp_v = (n == 3) || (n == 4);
      checks++; if (rv3 !== exp_v) begin failures++; $display("FAIL wr_rd_valid[%0d]: got %b expected %b", n, rv3, exp_v); end
      if (n == 3) begin
        checks++; if (rd3 !== 32'h0 || er3 !== 1'b0) begin failures++; $display("FAIL wr_rsp: got %h err=%b expected 00000000 0", rd3, er3); end
      end
      if (n == 4) begin
        checks++; if (rd3 !== 32'hDEADBEEF || er3 !== 1'b0) begin failures++; $display("FAIL rd_after_wr: got %h err=%b expected deadbeef 0", rd3, er3); end
      end
      if (n == 1) req_we = 1'b0;
      else req_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_byte_enable();
    req_and_wait(3, 1'b1, 4'hF, 5'd5, 32'h11223344, got, lat, dat, err);
    req_and_wait(3, 1'b1, 4'b0101, 5'd5, 32'hAABBCCDD, got, lat, dat, err);
    req_and_wait(3, 1'b0, 4'hF, 5'd5, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || dat !== 32'h11BB33DD) begin failures++; $display("FAIL byte_enable: got %h expected 11bb33dd", dat); end
    req_and_wait(3, 1'b1, 4'h0, 5'd5, 32'hFFFFFFFF, got, lat, dat, err);
    checks++; if (got !== 1'b1 || lat != 3 || err !== 1'b0) begin failures++; $display("FAIL be0_response: got valid=%b lat=%0d err=%b expected 1 3 0", got, lat, err); end
    req_and_wait(3, 1'b0, 4'hF, 5'd5, 32'h0, got, lat, dat, err);
    checks++; if (dat !== 32'h11BB33DD) begin failures++; $display("FAIL be0_noop: got %h expected 11bb33dd", dat); end
  endtask

  task automatic test_out_of_range();
    req_and_wait(3, 1'b1, 4'hF, 5'd4, 32'h0BADF00D, got, lat, dat, err);
    req_and_wait(3, 1'b1, 4'hF, 5'd20, 32'hFFFFFFFF, got, lat, dat, err);
    checks++; if (got !== 1'b1 || err !== 1'b1 || dat !== 32'h0) begin failures++; $display("FAIL oor_write: got valid=%b err=%b data=%h expected 1 1 00000000", got, err, dat); end
    req_and_wait(3, 1'b0, 4'hF, 5'd20, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || err !== 1'b1 || dat !== 32'h0) begin failures++; $display("FAIL oor_read: got valid=%b err=%b data=%h expected 1 1 00000000", got, err, dat); end
    req_and_wait(3, 1'b0, 4'hF, 5'd4, 32'h0, got, lat, dat, err);
    checks++; if (dat !== 32'h0BADF00D || err !== 1'b0) begin failures++; $display("FAIL oor_keeps_addr4: got %h err=%b expected 0badf00d 0", dat, err); end
    req_and_wait(3, 1'b0, 4'hF, 5'd16, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL oor_boundary16: got valid=%b err=%b expected 1 1", got, err); end
    req_and_wait(3, 1'b0, 4'hF, 5'd15, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || err !== 1'b0 || dat !== 32'h0) begin failures++; $display("FAIL inrange_boundary15: got valid=%b err=%b data=%h expected 1 0 00000000", got, err, dat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hDEADBEEF; exp_d[1] = 32'h0BADF00D; exp_d[2] = 32'h11BB33DD; exp_d[3] = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 5'd3;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++; if (rv4 !== ((n >= 4) && (n <= 7))) begin failures++; $display("FAIL b2b_valid[%0d]: got %b expected %b", n, rv4, (n >= 4) && (n <= 7)); end
      if (n >= 4 && n <= 7) begin
        checks++; if (rd4 !== exp_d[n-4]) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", n - 4, rd4, exp_d[n-4]); end
      end
      if (n < 4) req_addr = 5'(3 + n);
      else req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_flight();
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 5'd0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      req_addr = 5'(n);
    end
    @(negedge clk);
    checks++; if (rv4 !== 1'b1) begin failures++; $display("FAIL midrst_first_rsp: got %b expected 1", rv4); end
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (rv4 !== 1'b0 || bz4 !== 1'b1 || rdy4 !== 1'b0) begin failures++; $display("FAIL midrst_state: got v=%b busy=%b ready=%b expected 0 1 0", rv4, bz4, rdy4); end
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++; if (rv4 !== 1'b0 || bz4 !== 1'b1) begin failures++; $display("FAIL midrst_clear[%0d]: got v=%b busy=%b expected 0 1", i, rv4, bz4); end
    end
    @(negedge clk);
    checks++; if (rv4 !== 1'b0 || bz4 !== 1'b0 || rdy4 !== 1'b1) begin failures++; $display("FAIL midrst_done: got v=%b busy=%b ready=%b expected 0 0 1", rv4, bz4, rdy4); end
    // the reset itself must leave the no-clear array intact; the sweep zeroes the other
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++; if (rvn !== 1'b1 || rdn !== 32'h11BB33DD) begin failures++; $display("FAIL rst_keeps_array: got v=%b data=%h expected 1 11bb33dd", rvn, rdn); end
        req_valid = 1'b0;
      end
      if (n == 4) begin
        checks++; if (rv4 !== 1'b1 || rd4 !== 32'h0 || er4 !== 1'b0) begin failures++; $display("FAIL clear_zeroes: got v=%b data=%h err=%b expected 1 00000000 0", rv4, rd4, er4); end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_clear();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rdyn !== 1'b0 || bzn !== 1'b0) begin failures++; $display("FAIL noclear_in_reset: got ready=%b busy=%b expected 0 0", rdyn, bzn); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdyn !== 1'b1) begin failures++; $display("FAIL noclear_ready: got %b expected 1", rdyn); end
    req_and_wait(1, 1'b1, 4'hF, 5'd0, 32'hCAFEF00D, got, lat, dat, err);
    checks++; if (got !== 1'b1 || lat != 1 || dat !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL noclear_write: got valid=%b lat=%0d data=%h err=%b expected 1 1 00000000 0", got, lat, dat, err); end
    req_and_wait(1, 1'b0, 4'hF, 5'd0, 32'h0, got, lat, dat, err);
    checks++; if (got !== 1'b1 || lat != 1 || dat !== 32'hCAFEF00D) begin failures++; $display("FAIL noclear_read: got valid=%b lat=%0d data=%h expected 1 1 cafef00d", got, lat, dat); end
  endtask

  initial begin
    test_reset();
    test_clear_read();
    test_write_then_read();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_flight();
    test_no_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_ram_ctrl.md
SYNC_RAM_CTRL -- requirements
Module: sync_ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 16, request address width.
REQ-003 Parameter RAM_DEPTH, default 50000, number of words; SHALL be at most 2^ADDR_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1, cycles from request accept to response; legal range 1..4.
REQ-005 Parameter CLEAR_ON_RESET, default 1; 1 zero-fills the array after reset, 0 skips the fill.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_be  input  DATA_WIDTH/8  byte write enables; bit i covers data bits [8i+7:8i].
REQ-012 req_addr  input  ADDR_WIDTH  word address.
REQ-013 req_wdata  input  DATA_WIDTH  write data.
REQ-014 rsp_valid  output  1  one-cycle response strobe, one per accepted request.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data; 0 for write responses and error responses.
REQ-016 rsp_err  output  1  address out of range (req_addr >= RAM_DEPTH); valid with rsp_valid.
REQ-017 busy  output  1  high while in CLEAR state.

Function
REQ-018 Separate input and output data buses SHALL be used; no tri-state or inout ports.
REQ-019 States SHALL be CLEAR and RUN; req_ready = 1 only in RUN.
REQ-020 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-021 One request per cycle SHALL be accepted in RUN; no request-side backpressure beyond the CLEAR state.
REQ-022 rsp_valid SHALL assert exactly RD_LATENCY cycles after acceptance, for one cycle, in acceptance order; the response side has no backpressure.
REQ-023 Back-to-back accepted requests SHALL yield back-to-back responses (full throughput).
REQ-024 In-range write SHALL update only bytes with req_be bit = 1 at the accept edge; req_be = 0 SHALL be a no-op that still returns a response.
REQ-025 In-range read SHALL return the word contents as of the accept edge, including any write accepted on an earlier edge (a read accepted the cycle after a write to the same address returns new data).
REQ-026 Out-of-range write SHALL not modify the array; out-of-range read SHALL return rsp_rdata = 0; both SHALL return rsp_err = 1.
REQ-027 rsp_err SHALL be 0 for in-range requests and whenever rsp_valid = 0.
REQ-028 CLEAR (CLEAR_ON_RESET = 1): a counter from 0 to RAM_DEPTH-1 SHALL write all-zero to one word per cycle; transition to RUN on the cycle after address RAM_DEPTH-1 is written; CLEAR lasts exactly RAM_DEPTH cycles.
REQ-029 CLEAR_ON_RESET = 0: the block SHALL enter RUN on the first cycle after rst deasserts; array contents are undefined until written.
REQ-030 No response SHALL be generated during CLEAR; req_valid during CLEAR SHALL be ignored.

Reset
REQ-031 While rst = 1: req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = CLEAR_ON_RESET, clear counter = 0.
REQ-032 rst asserted mid-operation SHALL discard all in-flight responses (no rsp_valid on any cycle after the rst edge) and restart from CLEAR (or RUN when CLEAR_ON_RESET = 0).
REQ-033 Array contents SHALL not be modified by rst itself; only the CLEAR sequence zeroes them.

Verification (DATA_WIDTH=32, RAM_DEPTH=16, ADDR_WIDTH=5 unless stated)
REQ-034 CLEAR_ON_RESET=1, release rst -> busy=1, req_ready=0 for 16 cycles, then busy=0, req_ready=1; read addr 7 -> rdata 0x00000000, err 0.
REQ-035 RD_LATENCY=3: write 0xDEADBEEF to addr 3 (be=4'hF), then next cycle read addr 3 -> read response exactly 3 cycles after its accept, rdata 0xDEADBEEF.
REQ-036 Write 0x11223344 to addr 5, then write 0xAABBCCDD with be=4'b0101, read addr 5 -> 0x11BB33DD.
REQ-037 Write addr 20 with 0xFFFFFFFF, read addr 20 -> both responses err=1, read rdata=0; read addr 4 still returns its prior value.
REQ-038 RD_LATENCY=4, issue 4 back-to-back reads, assert rst the cycle after the 4th accept -> no rsp_valid observed afterwards until a new request is accepted; busy=1 for 16 cycles.
REQ-039 CLEAR_ON_RESET=0: req_ready=1 on the first cycle after rst deasserts; a write then read of addr 0 returns the written value.
